// File: rtl/argmax_stream_if.sv
// Stream bundle for argmax_stream: operand input channel, abort strobe and
// result output channel. The slave side is the argmax engine, the master side
// is whoever feeds operands and consumes results.
interface argmax_stream_if #(
  parameter int N = 10,
  parameter int M = 32
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_data;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  max;
  logic [IW-1:0] ind;

  modport slave (
    input  in_valid, in_data, abort, out_ready,
    output in_ready, out_valid, max, ind
  );

  modport master (
    output in_valid, in_data, abort, out_ready,
    input  in_ready, out_valid, max, ind
  );
endinterface

// File: rtl/argmax_stream.sv
// Streaming argmax engine. Operands of a frame arrive one per cycle; a single
// comparator folds each one into a running (max, index) accumulator, and the
// frame result is registered onto a valid/ready output. The next frame may
// fill the accumulator while the previous result waits for its consumer;
// only the last operand of a frame is held off when the result slot is busy.
module argmax_stream #(
  parameter int N      = 10,
  parameter int M      = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  argmax_stream_if.slave  s
);
  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] cnt;
  logic [M-1:0]  acc_max;
  logic [IW-1:0] acc_ind;

  logic accept;
  logic at_first;
  logic at_last;
  logic greater;
  logic take_new;

  assign at_first = (cnt == '0);
  assign at_last  = (cnt == LAST);

  // NOTE: in_ready is a pure function of state and out_ready; it must never
  // look at in_valid or in_data, or the handshake would form a loop upstream.
  assign s.in_ready = !(at_last && s.out_valid && !s.out_ready);
  assign accept     = s.in_valid && s.in_ready;

  // Single M-bit comparator; signed mode makes the MSB-set value the minimum.
  if (SIGNED) begin : g_signed
    assign greater = $signed(s.in_data) > $signed(acc_max);
  end else begin : g_unsigned
    assign greater = s.in_data > acc_max;
  end

  // First operand of a frame loads unconditionally; later ones only when
  // strictly greater, so ties keep the earliest index.
  assign take_new = at_first || greater;

  // Accumulator and position counter; abort rewinds to the start of a frame.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc_max <= '0;
      acc_ind <= '0;
    end else if (s.abort) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
      if (take_new) begin
        acc_max <= s.in_data;
        acc_ind <= cnt;
      end
    end
  end

  // Result slot: loads when the last operand of a frame is accepted, holds
  // while unconsumed, and clears on the handshake unless refilled that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_valid <= 1'b0;
      s.max       <= '0;
      s.ind       <= '0;
    end else if (accept && at_last && !s.abort) begin
      s.out_valid <= 1'b1;
      s.max       <= take_new ? s.in_data : acc_max;
      s.ind       <= take_new ? cnt : acc_ind;
    end else if (s.out_valid && s.out_ready) begin
      s.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream. Three instances share one stimulus stream:
//   0: N=4, M=8,  unsigned   1: N=4, M=8, signed   2: N=1, M=16, unsigned
// A frame-level model (buffer the frame, pick the earliest largest element)
// predicts every instance's outputs and is compared on each falling edge;
// directed literal checks pin the model to hand-computed values.
module tb_argmax_stream;
  localparam int NK [3] = '{4, 4, 1};
  localparam int MK [3] = '{8, 8, 16};
  localparam bit SK [3] = '{1'b0, 1'b1, 1'b0};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        abort;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  argmax_stream_if #(.N(4), .M(8))  if0 ();
  argmax_stream_if #(.N(4), .M(8))  if1 ();
  argmax_stream_if #(.N(1), .M(16)) if2 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data[7:0];
  assign if0.abort     = abort;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data[7:0];
  assign if1.abort     = abort;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_data   = in_data;
  assign if2.abort     = abort;
  assign if2.out_ready = out_ready;

  argmax_stream #(.N(4), .M(8),  .SIGNED(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .s(if0));
  argmax_stream #(.N(4), .M(8),  .SIGNED(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .s(if1));
  argmax_stream #(.N(1), .M(16), .SIGNED(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .s(if2));

  // Uniform views of the three instances' outputs.
  logic        d_ov  [3];
  logic        d_rdy [3];
  logic [31:0] d_max [3];
  logic [31:0] d_ind [3];
  assign d_ov[0]  = if0.out_valid;
  assign d_ov[1]  = if1.out_valid;
  assign d_ov[2]  = if2.out_valid;
  assign d_rdy[0] = if0.in_ready;
  assign d_rdy[1] = if1.in_ready;
  assign d_rdy[2] = if2.in_ready;
  assign d_max[0] = {24'd0, if0.max};
  assign d_max[1] = {24'd0, if1.max};
  assign d_max[2] = {16'd0, if2.max};
  assign d_ind[0] = {30'd0, if0.ind};
  assign d_ind[1] = {30'd0, if1.ind};
  assign d_ind[2] = {31'd0, if2.ind};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int          m_cnt [3];
  bit          m_ov  [3];
  logic [31:0] m_max [3];
  int          m_ind [3];
  logic [31:0] fbuf  [3][4];

  function automatic longint as_num(input logic [31:0] v, input int m, input bit sg);
    longint r;
    r = longint'(v);
    if (sg && v[m-1]) r = r - (longint'(1) << m);
    return r;
  endfunction

  function automatic bit model_ready(input int k);
    return !(m_cnt[k] == NK[k] - 1 && m_ov[k] && !out_ready);
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_ov[k] = 0; m_max[k] = 0; m_ind[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          m_cnt[k] = 0; m_ov[k] = 0; m_max[k] = 0; m_ind[k] = 0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          bit          hs;
          bit          done;
          int          best;
          logic [31:0] d;
          hs   = in_valid && model_ready(k);
          d    = {16'd0, in_data} & ((32'd1 << MK[k]) - 32'd1);
          done = 1'b0;
          best = 0;
          if (abort) begin
            m_cnt[k] = 0;
          end else if (hs) begin
            fbuf[k][m_cnt[k]] = d;
            if (m_cnt[k] == NK[k] - 1) begin
              for (int i = 1; i < NK[k]; i++)
                if (as_num(fbuf[k][i], MK[k], SK[k]) > as_num(fbuf[k][best], MK[k], SK[k]))
                  best = i;
              done     = 1'b1;
              m_cnt[k] = 0;
            end else begin
              m_cnt[k] = m_cnt[k] + 1;
            end
          end
          if (done) begin
            m_ov[k]  = 1'b1;
            m_max[k] = fbuf[k][best];
            m_ind[k] = best;
          end else if (m_ov[k] && out_ready) begin
            m_ov[k] = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: every falling edge out of reset, all instances.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("model u%0d out_valid", k), 32'(d_ov[k]), 32'(m_ov[k]));
          check($sformatf("model u%0d in_ready", k), 32'(d_rdy[k]), 32'(model_ready(k)));
          if (m_ov[k]) begin
            check($sformatf("model u%0d max", k), d_max[k], m_max[k]);
            check($sformatf("model u%0d ind", k), d_ind[k], 32'(m_ind[k]));
          end
        end
      end
    end
  end

  // One clock of stimulus; returns just after the active edge.
  task automatic cyc(input logic iv, input logic [15:0] d, input logic ab, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    abort     = ab;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string name, input int k, input logic ov,
                           input logic [31:0] mx, input logic [31:0] ix);
    check({name, " out_valid"}, 32'(d_ov[k]), 32'(ov));
    check({name, " max"}, d_max[k], mx);
    check({name, " ind"}, d_ind[k], ix);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b1;
    #3;
    check_res("reset u0", 0, 1'b0, 32'd0, 32'd0);
    check("reset u0 in_ready", 32'(d_rdy[0]), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Unsigned streaming with a tie, then an all-zero frame.
    cyc(1, 3, 0, 1); cyc(1, 9, 0, 1); cyc(1, 9, 0, 1); cyc(1, 2, 0, 1);
    check_res("tie u0", 0, 1'b1, 32'd9, 32'd1);
    check_res("tie u1", 1, 1'b1, 32'd9, 32'd1);
    cyc(1, 0, 0, 1);
    check("consume u0 out_valid", 32'(d_ov[0]), 32'd0);
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    check_res("zeros u0", 0, 1'b1, 32'd0, 32'd0);

    // Signed against unsigned on the same data.
    cyc(1, 16'h80, 0, 1); cyc(1, 16'hFF, 0, 1); cyc(1, 16'h7F, 0, 1); cyc(1, 16'h01, 0, 1);
    check_res("unsigned u0", 0, 1'b1, 32'hFF, 32'd1);
    check_res("signed u1", 1, 1'b1, 32'h7F, 32'd2);
    cyc(0, 0, 0, 1);

    // Back-pressure: the last operand of the second frame is held off.
    cyc(1, 10, 0, 0); cyc(1, 20, 0, 0); cyc(1, 5, 0, 0); cyc(1, 7, 0, 0);
    check_res("bp first u0", 0, 1'b1, 32'd20, 32'd1);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 50, 0, 0);
    check("bp u0 in_ready low", 32'(d_rdy[0]), 32'd0);
    cyc(1, 60, 0, 0);
    check_res("bp hold u0", 0, 1'b1, 32'd20, 32'd1);
    check("bp u0 still stalled", 32'(d_rdy[0]), 32'd0);
    in_valid = 1'b1; in_data = 60; out_ready = 1'b1;
    #1;
    check("bp u0 in_ready released", 32'(d_rdy[0]), 32'd1);
    @(posedge clk);
    #1;
    check_res("bp second u0", 0, 1'b1, 32'd60, 32'd3);
    cyc(0, 0, 0, 1);

    // Abort discards the partial frame and the operand accepted with it.
    cyc(1, 5, 0, 1); cyc(1, 6, 0, 1); cyc(1, 99, 1, 1);
    check("abort u0 out_valid", 32'(d_ov[0]), 32'd0);
    check("abort u2 out_valid", 32'(d_ov[2]), 32'd0);
    cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1);
    check("abort u0 no early result", 32'(d_ov[0]), 32'd0);
    cyc(1, 4, 0, 1);
    check_res("abort u0", 0, 1'b1, 32'd4, 32'd3);

    // Asynchronous reset mid-frame with a pending N=1 result.
    cyc(1, 2, 0, 1); cyc(1, 3, 0, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_res("async reset u0", 0, 1'b0, 32'd0, 32'd0);
    check("async reset u0 in_ready", 32'(d_rdy[0]), 32'd1);
    check("async reset u2 out_valid", 32'(d_ov[2]), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1, 7, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    check_res("after reset u0", 0, 1'b1, 32'd7, 32'd0);

    // N=1: every operand is a frame, results on consecutive cycles.
    cyc(1, 16'h1234, 0, 1);
    check_res("n1 first u2", 2, 1'b1, 32'h1234, 32'd0);
    cyc(1, 16'h0001, 0, 1);
    check_res("n1 second u2", 2, 1'b1, 32'h0001, 32'd0);

    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("idle u2 out_valid", 32'(d_ov[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
